// File: rtl/br_predict_unit_if.sv
// Fetch/resolve bus of the branch predictor: fetch lookup, resolve operands and training,
// mispredict pulse and statistics.
interface br_predict_unit_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32
);
   logic [PC_W-1:0]   fetch_pc;
   logic              pred_taken;
   logic              res_valid;
   logic [PC_W-1:0]   res_pc;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [2:0]        br_type;
   logic              res_pred;
   logic              br_true;
   logic              mispredict;
   logic [31:0]       stat_branches;
   logic [31:0]       stat_mispred;

   modport master (
      output fetch_pc, res_valid, res_pc, rd1, rd2, br_type, res_pred,
      input  pred_taken, br_true, mispredict, stat_branches, stat_mispred
   );

   modport slave (
      input  fetch_pc, res_valid, res_pc, rd1, rd2, br_type, res_pred,
      output pred_taken, br_true, mispredict, stat_branches, stat_mispred
   );
endinterface

// File: rtl/br_predict_unit.sv
// Branch condition evaluator with a PC-indexed 2-bit BHT and registered mispredict pulse.
// Optional resolve/mispredict statistics counters: define BR_PREDICT_STATS_EN.
module br_predict_unit #(
   parameter  int DATA_W    = 32,
   parameter  int PC_W      = 32,
   parameter  int BHT_DEPTH = 64,
   localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
   input logic             clk,
   input logic             rst_n,
   br_predict_unit_if.slave bus
);

   localparam logic signed [DATA_W-1:0] ZERO = '0;

   logic signed [DATA_W-1:0] w_rd1;
   logic signed [DATA_W-1:0] w_rd2;
   logic                     w_cond;
   logic                     w_valid_type;
   logic                     w_br_true;
   logic                     w_upd;
   logic                     w_mis_next;
   logic [IDX_W-1:0]         w_fetch_idx;
   logic [IDX_W-1:0]         w_res_idx;
   logic [1:0]               w_res_entry;
   logic [1:0]               w_next_entry;
   logic                     w_unused;

   logic [1:0]               r_bht [BHT_DEPTH];
   logic                     r_mispredict;

   assign w_rd1 = bus.rd1;
   assign w_rd2 = bus.rd2;

   always_comb begin
      w_cond = 1'b0;
      case (bus.br_type)
         3'b000:  w_cond = (w_rd1 == w_rd2);
         3'b001:  w_cond = (w_rd1 >  ZERO);
         3'b010:  w_cond = (w_rd1 <  ZERO);
         3'b011:  w_cond = (w_rd1 >= ZERO);
         3'b100:  w_cond = (w_rd1 <= ZERO);
         3'b101:  w_cond = (w_rd1 != w_rd2);
         default: w_cond = 1'b0;
      endcase
   end

   assign w_valid_type = (bus.br_type <= 3'b101);
   assign w_upd        = bus.res_valid & w_valid_type;
   assign w_br_true    = w_upd & w_cond;
   assign w_mis_next   = w_upd & (w_br_true ^ bus.res_pred);

   // PC bits [1:0] are the byte offset within a word and never select an entry
   assign w_fetch_idx = bus.fetch_pc[IDX_W+1:2];
   assign w_res_idx   = bus.res_pc[IDX_W+1:2];
   assign w_res_entry = r_bht[w_res_idx];

   always_comb begin
      w_next_entry = w_res_entry;
      if (w_br_true) begin
         if (w_res_entry != 2'b11) w_next_entry = w_res_entry + 2'b01;
      end else begin
         if (w_res_entry != 2'b00) w_next_entry = w_res_entry - 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
         r_mispredict <= 1'b0;
      end else begin
         if (w_upd) r_bht[w_res_idx] <= w_next_entry;
         r_mispredict <= w_mis_next;
      end
   end

   assign bus.pred_taken = r_bht[w_fetch_idx][1];
   assign bus.br_true    = w_br_true;
   assign bus.mispredict = r_mispredict;

`ifdef BR_PREDICT_STATS_EN
   logic [31:0] r_stat_branches;
   logic [31:0] r_stat_mispred;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_branches <= '0;
         r_stat_mispred  <= '0;
      end else begin
         if (w_upd && (r_stat_branches != 32'hFFFF_FFFF))
            r_stat_branches <= r_stat_branches + 32'd1;
         if (w_mis_next && (r_stat_mispred != 32'hFFFF_FFFF))
            r_stat_mispred <= r_stat_mispred + 32'd1;
      end
   end

   assign bus.stat_branches = r_stat_branches;
   assign bus.stat_mispred  = r_stat_mispred;
`else
   assign bus.stat_branches = '0;
   assign bus.stat_mispred  = '0;
`endif

   // PC bits outside the index window are deliberately ignored (aliasing is intended)
   assign w_unused = ^{bus.fetch_pc[PC_W-1:IDX_W+2], bus.fetch_pc[1:0],
                       bus.res_pc[PC_W-1:IDX_W+2], bus.res_pc[1:0]};

endmodule
